// File: rtl/wb_fib_initiator.sv
// -----------------------------------------------------------------------------
// wb_fib_initiator
//
// Wishbone classic initiator for the fibonacci user-project register block.
// A local client issues single read/write commands and gets a one-cycle
// response pulse. A bus-timeout guard turns a missing acknowledge into an
// error response. An optional poll mode periodically reads one register
// (FIBONACCI_VAL by default) and publishes the value it returns.
//
// Command handshake: a command transfers on a rising clock edge where
// cmd_valid and cmd_ready are both high. cmd_ready is high only in IDLE and
// does not depend on cmd_valid. The client holds cmd_we/off/sel/dat stable
// while cmd_valid is high and not yet accepted. Responses have no
// backpressure: rsp_valid is a single-cycle pulse, and rsp_err/rsp_dat hold
// until the next response.
//
// Ports:
//   wb_clk_i, wb_rst_ni        clock, asynchronous active-low reset
//   cmd_valid/ready            command handshake
//   cmd_we/off/sel/dat         command write flag, byte offset, selects, data
//   rsp_valid/err/dat          response pulse, error flag, read data
//   poll_en, poll_period       poll mode enable and period in cycles
//   poll_value, poll_update    last polled value and its load pulse
//   err_count                  saturating count of error responses
//   wbm_*                      Wishbone classic initiator port
//   o_dbg_state                current FSM state (IDLE=0, BUS=1, RESP=2)
// -----------------------------------------------------------------------------
module wb_fib_initiator #(
    parameter logic [31:0] BASE_ADDRESS = 32'h3000_0000,
    parameter int          TIMEOUT      = 16,
    parameter int          POLL_WIDTH   = 16,
    parameter logic [7:0]  POLL_OFFSET  = 8'h14
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_ni,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_we,
    input  logic [7:0]            cmd_off,
    input  logic [3:0]            cmd_sel,
    input  logic [31:0]           cmd_dat,

    output logic                  rsp_valid,
    output logic                  rsp_err,
    output logic [31:0]           rsp_dat,

    input  logic                  poll_en,
    input  logic [POLL_WIDTH-1:0] poll_period,
    output logic [31:0]           poll_value,
    output logic                  poll_update,

    output logic [7:0]            err_count,

    output logic                  wbm_cyc_o,
    output logic                  wbm_stb_o,
    output logic                  wbm_we_o,
    output logic [3:0]            wbm_sel_o,
    output logic [31:0]           wbm_adr_o,
    output logic [31:0]           wbm_dat_o,
    input  logic [31:0]           wbm_dat_i,
    input  logic                  wbm_ack_i,

    output logic [1:0]            o_dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Last timeout-counter value before the transfer is abandoned; the
    // counter starts at 0 in the first BUS cycle, so the bus is held for
    // exactly TIMEOUT cycles when no acknowledge arrives.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t                r_state;
    state_t                w_next_state;

    // Latched transaction
    logic                  r_we;
    logic [7:0]            r_off;
    logic [3:0]            r_sel;
    logic [31:0]           r_dat;
    logic                  r_is_poll;
    logic [7:0]            r_tcnt;

    // Response / publish registers
    logic                  r_rsp_valid;
    logic                  r_rsp_err;
    logic [31:0]           r_rsp_dat;
    logic [31:0]           r_poll_value;
    logic                  r_poll_update;
    logic [7:0]            r_err_count;

    // Poll scheduling
    logic [POLL_WIDTH-1:0] r_poll_timer;
    logic                  r_poll_pending;

    // FSM decisions
    logic                  w_latch_cmd;
    logic                  w_latch_poll;
    logic                  w_enter_resp;
    logic                  w_xfer_err;
    logic [31:0]           w_xfer_dat;
    logic                  w_resp_is_poll;
    logic                  w_in_bus;
    logic                  w_poll_due;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and transaction decisions
    // -------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_latch_cmd  = 1'b0;
        w_latch_poll = 1'b0;
        w_enter_resp = 1'b0;
        w_xfer_err   = 1'b0;
        w_xfer_dat   = 32'h0;

        case (r_state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    w_latch_cmd = 1'b1;
                    // Misaligned offsets never reach the bus.
                    if (cmd_off[1:0] != 2'b00) begin
                        w_next_state = ST_RESP;
                        w_enter_resp = 1'b1;
                        w_xfer_err   = 1'b1;
                    end else begin
                        w_next_state = ST_BUS;
                    end
                end else if (r_poll_pending) begin
                    w_latch_poll = 1'b1;
                    w_next_state = ST_BUS;
                end
            end

            ST_BUS: begin
                if (wbm_ack_i) begin
                    w_next_state = ST_RESP;
                    w_enter_resp = 1'b1;
                    w_xfer_dat   = r_we ? 32'h0 : wbm_dat_i;
                end else if (r_tcnt == TO_LAST) begin
                    w_next_state = ST_RESP;
                    w_enter_resp = 1'b1;
                    w_xfer_err   = 1'b1;
                end
            end

            ST_RESP: begin
                w_next_state = ST_IDLE;
            end

            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Only a transfer leaving BUS can belong to a poll; the IDLE->RESP
    // shortcut is always a misaligned command.
    assign w_resp_is_poll = (r_state == ST_BUS) && r_is_poll;

    // -------------------------------------------------------------------------
    // Transaction latch and timeout counter
    // -------------------------------------------------------------------------
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_we      <= 1'b0;
            r_off     <= 8'h0;
            r_sel     <= 4'h0;
            r_dat     <= 32'h0;
            r_is_poll <= 1'b0;
            r_tcnt    <= 8'h0;
        end else begin
            if (w_latch_cmd) begin
                r_we      <= cmd_we;
                r_off     <= cmd_off;
                r_sel     <= cmd_sel;
                r_dat     <= cmd_dat;
                r_is_poll <= 1'b0;
            end else if (w_latch_poll) begin
                r_we      <= 1'b0;
                r_off     <= POLL_OFFSET;
                r_sel     <= 4'hF;
                r_dat     <= 32'h0;
                r_is_poll <= 1'b1;
            end

            if (r_state == ST_BUS) begin
                r_tcnt <= r_tcnt + 8'd1;
            end else begin
                r_tcnt <= 8'h0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Responses, poll publication and error counter. All are loaded on the
    // edge entering RESP, so the pulses line up with the RESP cycle.
    // -------------------------------------------------------------------------
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_rsp_valid   <= 1'b0;
            r_rsp_err     <= 1'b0;
            r_rsp_dat     <= 32'h0;
            r_poll_value  <= 32'h0;
            r_poll_update <= 1'b0;
            r_err_count   <= 8'h0;
        end else begin
            r_rsp_valid   <= w_enter_resp && !w_resp_is_poll;
            r_poll_update <= w_enter_resp && w_resp_is_poll && !w_xfer_err;

            if (w_enter_resp) begin
                if (!w_resp_is_poll) begin
                    r_rsp_err <= w_xfer_err;
                    r_rsp_dat <= w_xfer_dat;
                end else if (!w_xfer_err) begin
                    r_poll_value <= w_xfer_dat;
                end

                if (w_xfer_err && (r_err_count != 8'hFF)) begin
                    r_err_count <= r_err_count + 8'd1;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Poll timer. Compare-and-clear keeps the timer at or below poll_period,
    // so it never wraps. A newly elapsed period wins over the clear caused by
    // a poll starting, which keeps period 0 polling back-to-back.
    // -------------------------------------------------------------------------
    assign w_poll_due = (r_poll_timer >= poll_period);

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_poll_timer   <= '0;
            r_poll_pending <= 1'b0;
        end else if (!poll_en) begin
            r_poll_timer   <= '0;
            r_poll_pending <= 1'b0;
        end else begin
            if (w_poll_due) begin
                r_poll_timer   <= '0;
                r_poll_pending <= 1'b1;
            end else begin
                r_poll_timer <= r_poll_timer + 1'b1;
                if (w_latch_poll) begin
                    r_poll_pending <= 1'b0;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs. Bus signals are decoded from state so that the asynchronous
    // reset drops cyc/stb without waiting for a clock edge.
    // -------------------------------------------------------------------------
    assign w_in_bus = (r_state == ST_BUS);

    assign cmd_ready = (r_state == ST_IDLE) && wb_rst_ni;

    assign wbm_cyc_o = w_in_bus;
    assign wbm_stb_o = w_in_bus;
    assign wbm_we_o  = w_in_bus && r_we;
    assign wbm_sel_o = w_in_bus ? r_sel : 4'h0;
    // Offset is OR-ed into the base; no carry into the upper bits.
    assign wbm_adr_o = w_in_bus ? (BASE_ADDRESS | {24'h0, r_off}) : 32'h0;
    assign wbm_dat_o = (w_in_bus && r_we) ? r_dat : 32'h0;

    assign rsp_valid   = r_rsp_valid;
    assign rsp_err     = r_rsp_err;
    assign rsp_dat     = r_rsp_dat;
    assign poll_value  = r_poll_value;
    assign poll_update = r_poll_update;
    assign err_count   = r_err_count;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_wb_fib_initiator.sv
// -----------------------------------------------------------------------------
// Directed bench for wb_fib_initiator: a small register-block responder with
// programmable ack delay, a bus monitor recording each burst, and a linear
// sequence of directed steps with hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_wb_fib_initiator;

  localparam logic [31:0] ID_VAL = 32'h4669_626f;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  // ---------------- DUT signals ----------------
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic [7:0]  cmd_off = 8'h0;
  logic [3:0]  cmd_sel = 4'h0;
  logic [31:0] cmd_dat = 32'h0;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_dat;
  logic        poll_en = 1'b0;
  logic [15:0] poll_period = 16'd0;
  logic [31:0] poll_value;
  logic        poll_update;
  logic [7:0]  err_count;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
  logic        wbm_ack_i;
  logic [1:0]  dbg_state;

  wb_fib_initiator dut (
    .wb_clk_i    (clk),
    .wb_rst_ni   (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_we      (cmd_we),
    .cmd_off     (cmd_off),
    .cmd_sel     (cmd_sel),
    .cmd_dat     (cmd_dat),
    .rsp_valid   (rsp_valid),
    .rsp_err     (rsp_err),
    .rsp_dat     (rsp_dat),
    .poll_en     (poll_en),
    .poll_period (poll_period),
    .poll_value  (poll_value),
    .poll_update (poll_update),
    .err_count   (err_count),
    .wbm_cyc_o   (wbm_cyc_o),
    .wbm_stb_o   (wbm_stb_o),
    .wbm_we_o    (wbm_we_o),
    .wbm_sel_o   (wbm_sel_o),
    .wbm_adr_o   (wbm_adr_o),
    .wbm_dat_o   (wbm_dat_o),
    .wbm_dat_i   (wbm_dat_i),
    .wbm_ack_i   (wbm_ack_i),
    .o_dbg_state (dbg_state)
  );

  // ---------------- responder ----------------
  int          ack_delay = 0;
  logic        rsp_stall = 1'b0;
  logic [31:0] fib_val = 32'd0;
  logic [31:0] scratch = 32'd0;
  int          bus_cnt = 0;

  always @(posedge clk) bus_cnt <= wbm_cyc_o ? bus_cnt + 1 : 0;

  always_comb begin
    wbm_ack_i = wbm_cyc_o && wbm_stb_o && !rsp_stall && (bus_cnt >= ack_delay);
    wbm_dat_i = 32'hDEAD_BEEF;
    if (wbm_ack_i && !wbm_we_o) begin
      case (wbm_adr_o[7:0])
        8'h04:        wbm_dat_i = ID_VAL;
        8'h14:        wbm_dat_i = fib_val;
        8'h18, 8'h1C: wbm_dat_i = scratch;
        default:      wbm_dat_i = 32'h0;
      endcase
    end
  end

  always @(posedge clk)
    if (wbm_ack_i && wbm_we_o && wbm_adr_o[7:0] == 8'h18) scratch <= wbm_dat_o;

  // ---------------- bus monitor ----------------
  logic        mon_prev_cyc = 1'b0;
  int          mon_len = 0;
  logic [31:0] mon_adr = 32'h0;
  logic [31:0] mon_dato = 32'h0;
  logic [3:0]  mon_sel = 4'h0;
  logic        mon_we = 1'b0;
  logic        mon_stable = 1'b1;
  int          mon_rsp_cnt = 0;
  logic [31:0] adr_q[$];

  always @(negedge clk) begin
    if (wbm_cyc_o && !mon_prev_cyc) begin
      mon_len    <= 1;
      mon_adr    <= wbm_adr_o;
      mon_dato   <= wbm_dat_o;
      mon_sel    <= wbm_sel_o;
      mon_we     <= wbm_we_o;
      mon_stable <= 1'b1;
      adr_q.push_back(wbm_adr_o);
    end else if (wbm_cyc_o) begin
      mon_len <= mon_len + 1;
      if (wbm_adr_o !== mon_adr || wbm_sel_o !== mon_sel ||
          wbm_we_o !== mon_we || wbm_dat_o !== mon_dato)
        mon_stable <= 1'b0;
    end
    mon_prev_cyc <= wbm_cyc_o;
    if (rsp_valid) mon_rsp_cnt <= mon_rsp_cnt + 1;
  end

  // ---------------- scoreboard counters / helpers ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one command and wait for its response. t_acc is the cycle number of
  // the accepting IDLE cycle; lat is cycles from that cycle to the response.
  task automatic do_cmd(input string tag, input logic we, input logic [7:0] off,
                        input logic [3:0] sel, input logic [31:0] dat,
                        output logic [31:0] rdat, output logic rerr,
                        output int lat, output int t_acc);
    int n;
    cmd_we = we; cmd_off = off; cmd_sel = sel; cmd_dat = dat; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 200) begin tick(); n++; end
    t_acc = cyc_n;
    tick();
    cmd_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 300) begin tick(); n++; end
    lat  = cyc_n - t_acc;
    rdat = rsp_dat;
    rerr = rsp_err;
    chk({tag, "_rsp_seen"}, 32'(rsp_valid), 32'd1);
  endtask

  // ---------------- directed sequence ----------------
  logic [31:0] rd;
  logic        re;
  int          lat, ta, tb2, t1, t2, n, base, rsp0;

  initial begin
    // Reset state (asynchronous, checked before any clock edge)
    #2;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_cyc", 32'(wbm_cyc_o), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    chk("rst_poll_value", poll_value, 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("idle_state", 32'(dbg_state), 32'd0);

    // Read ID, combinational ack in first BUS cycle
    ack_delay = 0;
    do_cmd("id", 1'b0, 8'h04, 4'hF, 32'h0, rd, re, lat, ta);
    chk("id_adr", mon_adr, 32'h3000_0004);
    chk("id_cyc_len", 32'(mon_len), 32'd1);
    chk("id_dat_o", mon_dato, 32'h0);
    chk("id_lat", 32'(lat), 32'd2);
    chk("id_dat", rd, ID_VAL);
    chk("id_err", 32'(re), 32'd0);

    // Write then read back, back-to-back
    do_cmd("wr", 1'b1, 8'h18, 4'hF, 32'hA5A5_1234, rd, re, lat, ta);
    chk("wr_we", 32'(mon_we), 32'd1);
    chk("wr_dat_o", mon_dato, 32'hA5A5_1234);
    chk("wr_adr", mon_adr, 32'h3000_0018);
    chk("wr_rsp_dat", rd, 32'h0);
    do_cmd("rb", 1'b0, 8'h1C, 4'hF, 32'h0, rd, re, lat, tb2);
    chk("rb_dat", rd, 32'hA5A5_1234);
    chk("rb_spacing", 32'(tb2 - ta), 32'd3);

    // Timeout: ack never comes
    rsp_stall = 1'b1;
    do_cmd("to", 1'b0, 8'h40, 4'hF, 32'h0, rd, re, lat, ta);
    chk("to_cyc_len", 32'(mon_len), 32'd16);
    chk("to_err", 32'(re), 32'd1);
    chk("to_dat", rd, 32'h0);
    chk("to_lat", 32'(lat), 32'd17);
    chk("to_err_count", 32'(err_count), 32'd1);
    rsp_stall = 1'b0;

    // Misaligned offset: error, no bus cycle
    base = adr_q.size();
    do_cmd("mis", 1'b0, 8'h06, 4'hF, 32'h0, rd, re, lat, ta);
    chk("mis_err", 32'(re), 32'd1);
    chk("mis_dat", rd, 32'h0);
    chk("mis_lat", 32'(lat), 32'd1);
    chk("mis_no_bus", 32'(adr_q.size()), 32'(base));
    chk("mis_err_count", 32'(err_count), 32'd2);

    // Poll mode: period 10 -> one poll every 11 cycles
    rsp0 = mon_rsp_cnt;
    fib_val = 32'd55;
    poll_period = 16'd10;
    poll_en = 1'b1;
    n = 0;
    while (!poll_update && n < 100) begin tick(); n++; end
    t1 = cyc_n;
    chk("poll1_update", 32'(poll_update), 32'd1);
    chk("poll1_value", poll_value, 32'd55);
    chk("poll1_adr", mon_adr, 32'h3000_0014);
    chk("poll1_sel", 32'(mon_sel), 32'hF);
    fib_val = 32'd89;
    tick();
    n = 0;
    while (!poll_update && n < 100) begin tick(); n++; end
    t2 = cyc_n;
    chk("poll2_update", 32'(poll_update), 32'd1);
    chk("poll2_value", poll_value, 32'd89);
    chk("poll_spacing", 32'(t2 - t1), 32'd11);
    chk("poll_no_rsp", 32'(mon_rsp_cnt), 32'(rsp0));
    poll_en = 1'b0;
    repeat (4) tick();
    chk("poll_value_hold", poll_value, 32'd89);

    // Priority: command pending alongside a pending poll, ack delayed 3
    ack_delay = 3;
    fib_val = 32'd144;
    poll_period = 16'd0;
    poll_en = 1'b1;
    n = 0;
    while (!(wbm_cyc_o && wbm_adr_o == 32'h3000_0014) && n < 50) begin tick(); n++; end
    chk("pri_poll_seen", 32'(wbm_cyc_o), 32'd1);
    base = adr_q.size();
    do_cmd("pri", 1'b0, 8'h04, 4'h3, 32'h0, rd, re, lat, ta);
    chk("pri_dat", rd, ID_VAL);
    chk("pri_cyc_len", 32'(mon_len), 32'd4);
    chk("pri_stable", 32'(mon_stable), 32'd1);
    chk("pri_sel", 32'(mon_sel), 32'h3);
    n = 0;
    while (adr_q.size() < base + 2 && n < 50) begin tick(); n++; end
    poll_en = 1'b0;
    chk("pri_bursts", 32'(adr_q.size() >= base + 2), 32'd1);
    if (adr_q.size() >= base + 2) begin
      chk("pri_first_cmd", adr_q[base], 32'h3000_0004);
      chk("pri_then_poll", adr_q[base+1], 32'h3000_0014);
    end
    ack_delay = 0;
    repeat (8) tick();
    chk("pri_poll_value", poll_value, 32'd144);
    chk("pri_err_count", 32'(err_count), 32'd2);

    // Asynchronous reset during cycle 2 of a stalled read
    rsp_stall = 1'b1;
    cmd_we = 1'b0; cmd_off = 8'h08; cmd_sel = 4'hF; cmd_valid = 1'b1;
    n = 0;
    while (!wbm_cyc_o && n < 20) begin tick(); n++; end
    cmd_valid = 1'b0;
    tick();
    chk("ar_bus_state", 32'(dbg_state), 32'd1);
    chk("ar_cyc_before", 32'(wbm_cyc_o), 32'd1);
    rsp0 = mon_rsp_cnt;
    rst_n = 1'b0;
    #1;
    chk("ar_cyc_drop", 32'(wbm_cyc_o), 32'd0);
    chk("ar_stb_drop", 32'(wbm_stb_o), 32'd0);
    tick(); tick();
    chk("ar_ready_in_rst", 32'(cmd_ready), 32'd0);
    rsp_stall = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("ar_ready_after", 32'(cmd_ready), 32'd1);
    chk("ar_err_count", 32'(err_count), 32'd0);
    chk("ar_no_rsp", 32'(mon_rsp_cnt), 32'(rsp0));
    chk("ar_poll_value", poll_value, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
